// File: rtl/uctl_bank_arbiter.sv
// uctl_bank_arbiter
// Shares the single-port buffer SRAM between four bank sequencers.
// An idle cycle picks one requester round-robin. The winner then owns the
// memory for a burst of up to 2^BURST_W beats at incrementing addresses.
// Read data is steered back to the owner one cycle after each read beat.
//
// Handshake: uctl_bankReq[i] is a level request held for the whole burst.
// Each cycle uctl_bankAck[i] is high, one beat is issued to memory and the
// requester must present its next write word on the following cycle.
// Dropping the request while granted ends the burst without issuing a beat.
// uctl_bankRdVld[i] is a one-cycle pulse that qualifies uctl_bankRdData.
//
// The FSM is one bit, IDLE or BURST, and uctl_arbBusy is that state bit.
module uctl_bank_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) (
  input  logic                   uctl_coreClk,
  input  logic                   uctl_coreRst_n,
  input  logic [3:0]             uctl_bankReq,
  input  logic [3:0]             uctl_bankRw,
  input  logic [4*BURST_W-1:0]   uctl_bankLen,
  input  logic [4*ADDR_W-1:0]    uctl_bankAddr,
  input  logic [4*DATA_W-1:0]    uctl_bankWrData,
  output logic [3:0]             uctl_bankGnt,
  output logic [3:0]             uctl_bankAck,
  output logic [3:0]             uctl_bankRdVld,
  output logic [DATA_W-1:0]      uctl_bankRdData,
  output logic                   uctl_memCe,
  output logic                   uctl_memRw,
  output logic [ADDR_W-1:0]      uctl_memAddr,
  output logic [DATA_W-1:0]      uctl_memWrData,
  input  logic [DATA_W-1:0]      uctl_memRdData,
  output logic                   uctl_arbBusy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [3:0]           gnt_q;       // one-hot owner of the current burst
  logic [3:0]           last_gnt_q;  // one-hot owner of the previous burst
  logic [ADDR_W-1:0]    base_q;      // burst start address
  logic [BURST_W-1:0]   len_q;       // beats-1 of the current burst
  logic                 rw_q;        // burst direction, 1 = read
  logic [BURST_W-1:0]   beat_cnt_q;  // beats already issued in this burst
  logic [3:0]           rd_pipe_q;   // owner of a read beat issued last cycle

  logic                 any_req;
  logic [1:0]           last_idx;
  logic [1:0]           cand_idx;
  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic [3:0]           pick_oh;
  logic [1:0]           win_idx;
  logic                 win_req;
  logic                 issue;
  logic                 last_beat;

  // Binary index of a one-hot 4-bit vector; zero vector maps to 0.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign any_req  = |uctl_bankReq;
  assign last_idx = onehot_idx(last_gnt_q);
  assign win_idx  = onehot_idx(gnt_q);

  // Round-robin pick: search upward starting one past the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    pick_oh    = 4'b0000;
    cand_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand_idx = last_idx + 2'(k + 1);
      if (!pick_found && uctl_bankReq[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    if (pick_found) begin
      pick_oh[pick_idx] = 1'b1;
    end
  end

  // A beat goes out only while the owner keeps its request up.
  assign win_req   = |(uctl_bankReq & gnt_q);
  assign issue     = (state_q == BURST) && win_req;
  assign last_beat = issue && (beat_cnt_q == len_q);

  // FSM state register.
  always_ff @(posedge uctl_coreClk or negedge uctl_coreRst_n) begin
    if (!uctl_coreRst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: grant from IDLE, leave BURST on last beat or abort.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (!win_req || last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst context: captured once in the grant cycle, only the beat count moves.
  always_ff @(posedge uctl_coreClk or negedge uctl_coreRst_n) begin
    if (!uctl_coreRst_n) begin
      gnt_q      <= 4'b0000;
      last_gnt_q <= 4'b1000;
      base_q     <= '0;
      len_q      <= '0;
      rw_q       <= 1'b0;
      beat_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (any_req) begin
        gnt_q      <= pick_oh;
        last_gnt_q <= pick_oh;
        base_q     <= uctl_bankAddr[pick_idx*ADDR_W +: ADDR_W];
        len_q      <= uctl_bankLen[pick_idx*BURST_W +: BURST_W];
        rw_q       <= uctl_bankRw[pick_idx];
        beat_cnt_q <= '0;
      end
    end else if (issue) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // Read return steering: remember who issued a read beat this cycle.
  always_ff @(posedge uctl_coreClk or negedge uctl_coreRst_n) begin
    if (!uctl_coreRst_n) begin
      rd_pipe_q <= 4'b0000;
    end else if (issue && rw_q) begin
      rd_pipe_q <= gnt_q;
    end else begin
      rd_pipe_q <= 4'b0000;
    end
  end

  // Memory and requester outputs, forced to zero unless a beat is issued.
  always_comb begin
    uctl_memCe     = 1'b0;
    uctl_memRw     = 1'b0;
    uctl_memAddr   = '0;
    uctl_memWrData = '0;
    uctl_bankAck   = 4'b0000;
    if (issue) begin
      uctl_memCe     = 1'b1;
      uctl_memRw     = rw_q;
      uctl_memAddr   = base_q + ADDR_W'(beat_cnt_q);
      uctl_memWrData = uctl_bankWrData[win_idx*DATA_W +: DATA_W];
      uctl_bankAck   = gnt_q;
    end
  end

  assign uctl_bankGnt    = (state_q == BURST) ? gnt_q : 4'b0000;
  assign uctl_arbBusy    = (state_q == BURST);
  assign uctl_bankRdVld  = rd_pipe_q;
  assign uctl_bankRdData = uctl_memRdData;

endmodule

// File: tb/tb_uctl_bank_arbiter.sv
// Directed bench for uctl_bank_arbiter: single write burst, read return,
// round-robin order, fairness under re-request, abort with address wrap,
// and asynchronous reset in the middle of a read burst.
module tb_uctl_bank_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [3:0]           req;
  logic [3:0]           rw;
  logic [4*BURST_W-1:0] len;
  logic [4*ADDR_W-1:0]  addr;
  logic [4*DATA_W-1:0]  wr_data;
  logic [3:0]           gnt;
  logic [3:0]           ack;
  logic [3:0]           rd_vld;
  logic [DATA_W-1:0]    rd_data;
  logic                 mem_ce;
  logic                 mem_rw;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wr_data;
  logic [DATA_W-1:0]    mem_rd_data;
  logic                 busy;

  uctl_bank_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BURST_W(BURST_W)
  ) dut (
    .uctl_coreClk   (clk),
    .uctl_coreRst_n (rst_n),
    .uctl_bankReq   (req),
    .uctl_bankRw    (rw),
    .uctl_bankLen   (len),
    .uctl_bankAddr  (addr),
    .uctl_bankWrData(wr_data),
    .uctl_bankGnt   (gnt),
    .uctl_bankAck   (ack),
    .uctl_bankRdVld (rd_vld),
    .uctl_bankRdData(rd_data),
    .uctl_memCe     (mem_ce),
    .uctl_memRw     (mem_rw),
    .uctl_memAddr   (mem_addr),
    .uctl_memWrData (mem_wr_data),
    .uctl_memRdData (mem_rd_data),
    .uctl_arbBusy   (busy)
  );

  // Memory model: a read returns its own address one cycle later.
  always_ff @(posedge clk) begin
    if (mem_ce && mem_rw) begin
      mem_rd_data <= DATA_W'(mem_addr);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic r, input logic [BURST_W-1:0] l,
                          input logic [ADDR_W-1:0] a);
    rw[i]                    = r;
    len[i*BURST_W +: BURST_W] = l;
    addr[i*ADDR_W +: ADDR_W]  = a;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " ce"},  64'(mem_ce), 64'd0);
    check_val({tag, " gnt"}, 64'(gnt),    64'd0);
    check_val({tag, " ack"}, 64'(ack),    64'd0);
  endtask

  task automatic pulse_reset();
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] ea;
    rst_n   = 1'b0;
    req     = '0;
    rw      = '0;
    len     = '0;
    addr    = '0;
    wr_data = '0;

    // Reset values, checked while reset is still asserted.
    #3;
    check_val("rst ce",    64'(mem_ce),      64'd0);
    check_val("rst rw",    64'(mem_rw),      64'd0);
    check_val("rst addr",  64'(mem_addr),    64'd0);
    check_val("rst wdata", 64'(mem_wr_data), 64'd0);
    check_val("rst gnt",   64'(gnt),         64'd0);
    check_val("rst ack",   64'(ack),         64'd0);
    check_val("rst rdvld", 64'(rd_vld),      64'd0);
    check_val("rst busy",  64'(busy),        64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single write: lane 2, 4 beats from 0x0010 ----
    next_cycle();
    set_lane(2, 1'b0, 4'd3, 16'h0010);
    req = 4'b0100;
    sample();
    check_idle("t1 req cycle");
    for (int b = 0; b < 4; b++) exp_q.push_back(16'h0010 + 16'(b));
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      wr_data[2*DATA_W +: DATA_W] = 32'hA0 + 32'(b);
      sample();
      ea = exp_q.pop_front();
      check_val("t1 ce",    64'(mem_ce),      64'd1);
      check_val("t1 rw",    64'(mem_rw),      64'd0);
      check_val("t1 addr",  64'(mem_addr),    64'(ea));
      check_val("t1 wdata", 64'(mem_wr_data), 64'h0A0 + 64'(b));
      check_val("t1 ack",   64'(ack),         64'b0100);
      check_val("t1 gnt",   64'(gnt),         64'b0100);
      check_val("t1 busy",  64'(busy),        64'd1);
    end
    next_cycle();
    req = 4'b0000;
    sample();
    check_idle("t1 bubble");
    check_val("t1 bubble busy", 64'(busy), 64'd0);

    // ---- read return: lane 1, 2 beats from 0x0020 ----
    next_cycle();
    set_lane(1, 1'b1, 4'd1, 16'h0020);
    req = 4'b0010;
    sample();
    check_idle("t2 req cycle");
    for (int b = 0; b < 2; b++) begin
      next_cycle();
      sample();
      check_val("t2 rw",   64'(mem_rw),   64'd1);
      check_val("t2 addr", 64'(mem_addr), 64'h20 + 64'(b));
      check_val("t2 ack",  64'(ack),      64'b0010);
      if (b == 0) begin
        check_val("t2 rdvld b0", 64'(rd_vld), 64'd0);
      end else begin
        check_val("t2 rdvld b1", 64'(rd_vld),  64'b0010);
        check_val("t2 rddata0",  64'(rd_data), 64'h20);
      end
    end
    next_cycle();
    req = 4'b0000;
    sample();
    check_val("t2 idle ce",   64'(mem_ce),  64'd0);
    check_val("t2 last vld",  64'(rd_vld),  64'b0010);
    check_val("t2 rddata1",   64'(rd_data), 64'h21);
    next_cycle();
    sample();
    check_val("t2 vld clear", 64'(rd_vld),  64'd0);

    // ---- round-robin from reset: all four single-beat writers ----
    pulse_reset();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 4'd0, 16'h0100 * 16'(i + 1));
    next_cycle();
    req = 4'b1111;
    sample();
    check_idle("t3 req cycle");
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      sample();
      check_val("t3 gnt",  64'(gnt),      64'(4'b0001 << (k % 4)));
      check_val("t3 addr", 64'(mem_addr), 64'h100 * 64'((k % 4) + 1));
      check_val("t3 ce",   64'(mem_ce),   64'd1);
      next_cycle();
      if (k == 7) req = 4'b1001;
      sample();
      check_val("t3 bubble ce", 64'(mem_ce), 64'd0);
    end

    // ---- fairness: lanes 0 and 3 re-request continuously, last owner was 3 ----
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      sample();
      check_val("t4 gnt", 64'(gnt), (k % 2 == 0) ? 64'b0001 : 64'b1000);
      next_cycle();
      if (k == 3) req = 4'b0000;
      sample();
      check_val("t4 bubble ce", 64'(mem_ce), 64'd0);
    end

    // ---- abort with address wrap: lane 3, len 15 from 0xFFFE ----
    next_cycle();
    set_lane(3, 1'b0, 4'd15, 16'hFFFE);
    req = 4'b1000;
    sample();
    check_idle("t5 req cycle");
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      if (b == 1) begin
        // A non-winner raising its request mid-burst changes nothing.
        set_lane(0, 1'b1, 4'd2, 16'h1234);
        req[0] = 1'b1;
      end
      sample();
      ea = exp_q.pop_front();
      check_val("t5 addr", 64'(mem_addr), 64'(ea));
      check_val("t5 ack",  64'(ack),      64'b1000);
      check_val("t5 gnt",  64'(gnt),      64'b1000);
    end
    next_cycle();
    req = 4'b0000;
    sample();
    check_val("t5 abort ce",   64'(mem_ce), 64'd0);
    check_val("t5 abort ack",  64'(ack),    64'd0);
    check_val("t5 abort busy", 64'(busy),   64'd1);
    next_cycle();
    sample();
    check_val("t5 after busy", 64'(busy), 64'd0);
    check_val("t5 after gnt",  64'(gnt),  64'd0);

    // ---- reset during beat 2 of a read: lane 1, 4 beats from 0x0040 ----
    next_cycle();
    set_lane(1, 1'b1, 4'd3, 16'h0040);
    req = 4'b0010;
    sample();
    check_idle("t6 req cycle");
    next_cycle();
    sample();
    check_val("t6 beat0 addr", 64'(mem_addr), 64'h40);
    next_cycle();
    check_val("t6 beat1 ce",  64'(mem_ce), 64'd1);
    check_val("t6 beat1 vld", 64'(rd_vld), 64'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("t6 rst ce",    64'(mem_ce), 64'd0);
    check_val("t6 rst gnt",   64'(gnt),    64'd0);
    check_val("t6 rst ack",   64'(ack),    64'd0);
    check_val("t6 rst rdvld", 64'(rd_vld), 64'd0);
    check_val("t6 rst busy",  64'(busy),   64'd0);
    set_lane(0, 1'b0, 4'd0, 16'h0500);
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    sample();
    check_val("t6 first gnt",  64'(gnt),      64'b0001);
    check_val("t6 first addr", 64'(mem_addr), 64'h500);
    next_cycle();
    req = 4'b0000;
    sample();
    check_idle("t6 end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
